// File: rtl/lz77_pkg.sv
// lz77_pkg: shared constants, FSM state encoding and codeword layout for the
// LZ77 encoder/decoder pair (4-bit symbols, 9-symbol window, 7-symbol matches).
package lz77_pkg;

  localparam int         SEARCH_WIN = 9;
  localparam int         MAX_MATCH  = 7;
  localparam logic [7:0] END_CHAR   = 8'h24;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_EMIT   = 2'd2,
    ST_DONE   = 2'd3
  } lz77_state_e;

  typedef struct packed {
    logic [3:0] offset;
    logic [2:0] match_len;
    logic [7:0] char_nxt;
  } lz77_codeword_t;

endpackage

// File: rtl/lz77_match_len.sv
// lz77_match_len: length of the common prefix between one candidate window and
// the lookahead, capped at 'limit'. An illegal candidate always yields 0.
module lz77_match_len
  import lz77_pkg::*;
(
  input  logic [MAX_MATCH-1:0][3:0] win_nib,
  input  logic [MAX_MATCH-1:0][3:0] look_nib,
  input  logic                      legal,
  input  logic [2:0]                limit,
  output logic [2:0]                len
);

  logic run;

  // Count matching symbols from the start; the first mismatch or the limit stops it.
  always_comb begin
    len = 3'd0;
    run = legal;
    for (int i = 0; i < MAX_MATCH; i++) begin
      if (run && (3'(i) < limit) && (win_nib[i] == look_nib[i])) begin
        len = len + 3'd1;
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lz77_encoder.sv
// lz77_encoder: buffers a 4-bit-symbol string terminated by '$', then emits one
// (offset, match_len, char_nxt) codeword per search pass and raises finish.
// Build option: LZ77_ENC_PARALLEL_SEARCH_EN evaluates all 9 offsets in one cycle
// (2-cycle cadence); without it one offset is examined per cycle (10-cycle cadence).
module lz77_encoder
  import lz77_pkg::*;
#(
  parameter int MAX_LEN = 2048
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [7:0] chardata,
  output logic       encode,
  output logic       valid,
  output logic [3:0] offset,
  output logic [2:0] match_len,
  output logic [7:0] char_nxt,
  output logic       finish
);

`ifdef LZ77_ENC_PARALLEL_SEARCH_EN
  localparam int NCAND = SEARCH_WIN;
`else
  localparam int NCAND = 1;
`endif
  // Spare tail entries let the lookahead read past N without bounds logic.
  localparam int DEPTH     = MAX_LEN + MAX_MATCH;
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int LAST_CAND = SEARCH_WIN - NCAND;

  localparam logic [1:0] S_LOAD   = ST_LOAD;
  localparam logic [1:0] S_SEARCH = ST_SEARCH;
  localparam logic [1:0] S_EMIT   = ST_EMIT;
  localparam logic [1:0] S_DONE   = ST_DONE;

  logic [3:0]                buf_mem [DEPTH];
  logic [1:0]                state_reg;
  logic [IDX_W-1:0]          wr_reg, n_reg, cur_reg;
  logic [3:0]                cand_reg;
  logic [3:0]                best_off_reg;
  logic [2:0]                best_len_reg;
  lz77_codeword_t            cw_reg;
  logic                      valid_reg, finish_reg, encode_reg;

  logic                      load_wr;
  logic [IDX_W-1:0]          remain;
  logic [2:0]                limit;
  logic [MAX_MATCH-1:0][3:0] look_nib;
  logic [NCAND-1:0][3:0]     cand_off;
  logic [NCAND-1:0][2:0]     cand_len;
  logic [3:0]                fold_off;
  logic [2:0]                fold_len;
  logic                      last_cand;
  logic [IDX_W-1:0]          emit_idx;
  logic                      emit_end;
  logic [7:0]                emit_char;

  assign load_wr   = !reset && (state_reg == S_LOAD) && char_valid && (chardata != END_CHAR);
  assign remain    = n_reg - cur_reg;
  assign limit     = (remain >= IDX_W'(MAX_MATCH)) ? 3'(MAX_MATCH) : remain[2:0];
  assign last_cand = (cand_reg == 4'(LAST_CAND));
  assign emit_idx  = cur_reg + IDX_W'(best_len_reg);
  assign emit_end  = (emit_idx == n_reg);
  assign emit_char = emit_end ? END_CHAR : {4'h0, buf_mem[emit_idx]};

  // Symbol store; only the count is cleared by reset, contents are don't-care.
  always_ff @(posedge clk) begin
    if (load_wr) begin
      buf_mem[wr_reg] <= chardata[3:0];
    end
  end

  genvar gi, gj;
  for (gi = 0; gi < MAX_MATCH; gi++) begin : g_look
    assign look_nib[gi] = buf_mem[cur_reg + IDX_W'(gi)];
  end

  for (gi = 0; gi < NCAND; gi++) begin : g_cand
    logic                      legal;
    logic [IDX_W-1:0]          base;
    logic [MAX_MATCH-1:0][3:0] win_nib;

    if (NCAND == 1) begin : g_serial_off
      assign cand_off[gi] = cand_reg;
    end else begin : g_fixed_off
      assign cand_off[gi] = 4'(gi);
    end

    // Candidate window starts o+1 symbols behind cur; it may run into the lookahead.
    assign legal = (IDX_W'(cand_off[gi]) < cur_reg);
    assign base  = cur_reg - IDX_W'(1) - IDX_W'(cand_off[gi]);

    for (gj = 0; gj < MAX_MATCH; gj++) begin : g_win
      assign win_nib[gj] = legal ? buf_mem[base + IDX_W'(gj)] : 4'h0;
    end

    lz77_match_len u_match_len (
      .win_nib  (win_nib),
      .look_nib (look_nib),
      .legal    (legal),
      .limit    (limit),
      .len      (cand_len[gi])
    );
  end

  // Running best: strictly longer wins, so ties keep the smaller offset.
  always_comb begin
    fold_off = (cand_reg == 4'd0) ? 4'd0 : best_off_reg;
    fold_len = (cand_reg == 4'd0) ? 3'd0 : best_len_reg;
    for (int k = 0; k < NCAND; k++) begin
      if (cand_len[k] > fold_len) begin
        fold_len = cand_len[k];
        fold_off = cand_off[k];
      end
    end
  end

  // Control FSM: load, search passes, codeword emission and sticky finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_LOAD;
      wr_reg       <= '0;
      n_reg        <= '0;
      cur_reg      <= '0;
      cand_reg     <= '0;
      best_off_reg <= '0;
      best_len_reg <= '0;
      cw_reg       <= '0;
      valid_reg    <= 1'b0;
      finish_reg   <= 1'b0;
      encode_reg   <= 1'b0;
    end else begin
      valid_reg  <= 1'b0;
      encode_reg <= 1'b1;
      case (state_reg)
        S_LOAD: begin
          if (char_valid) begin
            if (chardata == END_CHAR) begin
              n_reg     <= wr_reg;
              cur_reg   <= '0;
              cand_reg  <= '0;
              state_reg <= S_SEARCH;
            end else begin
              wr_reg <= wr_reg + IDX_W'(1);
              if (wr_reg == IDX_W'(MAX_LEN - 1)) begin
                n_reg     <= IDX_W'(MAX_LEN);
                cur_reg   <= '0;
                cand_reg  <= '0;
                state_reg <= S_SEARCH;
              end
            end
          end
        end
        S_SEARCH: begin
          best_off_reg <= fold_off;
          best_len_reg <= fold_len;
          if (last_cand) begin
            cand_reg  <= '0;
            state_reg <= S_EMIT;
          end else begin
            cand_reg <= cand_reg + 4'd1;
          end
        end
        S_EMIT: begin
          valid_reg        <= 1'b1;
          cw_reg.offset    <= best_off_reg;
          cw_reg.match_len <= best_len_reg;
          cw_reg.char_nxt  <= emit_char;
          cur_reg          <= emit_idx + IDX_W'(1);
          state_reg        <= emit_end ? S_DONE : S_SEARCH;
        end
        default: begin
          finish_reg <= 1'b1;
          encode_reg <= 1'b0;
        end
      endcase
    end
  end

  assign valid     = valid_reg;
  assign finish    = finish_reg;
  assign encode    = encode_reg;
  assign offset    = cw_reg.offset;
  assign match_len = cw_reg.match_len;
  assign char_nxt  = cw_reg.char_nxt;

endmodule

// File: tb/tb_lz77_encoder.sv
// tb_lz77_encoder: directed strings with hand-computed codewords. Stimulus pushes
// expected codewords into per-instance queues; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_lz77_encoder;
  import lz77_pkg::*;

`ifdef LZ77_ENC_PARALLEL_SEARCH_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       char_valid [2];
  logic [7:0] chardata   [2];
  logic       encode_s   [2];
  logic       valid_s    [2];
  logic       finish_s   [2];
  logic [3:0] offset_s   [2];
  logic [2:0] len_s      [2];
  logic [7:0] char_s     [2];

  always #5 clk = ~clk;

  lz77_encoder dut_a (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid[0]),
    .chardata   (chardata[0]),
    .encode     (encode_s[0]),
    .valid      (valid_s[0]),
    .offset     (offset_s[0]),
    .match_len  (len_s[0]),
    .char_nxt   (char_s[0]),
    .finish     (finish_s[0])
  );

  lz77_encoder #(.MAX_LEN(16)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid[1]),
    .chardata   (chardata[1]),
    .encode     (encode_s[1]),
    .valid      (valid_s[1]),
    .offset     (offset_s[1]),
    .match_len  (len_s[1]),
    .char_nxt   (char_s[1]),
    .finish     (finish_s[1])
  );

  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  lz77_codeword_t exp_q0[$];
  lz77_codeword_t exp_q1[$];
  logic [7:0]     stim_q[$];
  int             last_valid [2];
  logic           fin_prev   [2];
  lz77_codeword_t mon_got, mon_want;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_cw(input int inst, input logic [3:0] o, input logic [2:0] l, input logic [7:0] c);
    lz77_codeword_t cw;
    cw.offset = o;
    cw.match_len = l;
    cw.char_nxt = c;
    if (inst == 0) exp_q0.push_back(cw);
    else exp_q1.push_back(cw);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop and compare on every codeword strobe; check finish follows by one cycle.
  always @(negedge clk) begin
    if (reset) begin
      fin_prev[0] = 1'b0;
      fin_prev[1] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (valid_s[k]) begin
          mon_got.offset    = offset_s[k];
          mon_got.match_len = len_s[k];
          mon_got.char_nxt  = char_s[k];
          $display("codeword inst=%0d off=%0d len=%0d char=%02h cycle=%0d",
                   k, offset_s[k], len_s[k], char_s[k], cyc);
          last_valid[k] = cyc;
          if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_codeword inst=%0d: got 0x%0h expected none", k, int'(mon_got));
          end else begin
            if (k == 0) mon_want = exp_q0.pop_front();
            else mon_want = exp_q1.pop_front();
            check($sformatf("codeword_inst%0d", k), int'(mon_got), int'(mon_want));
          end
        end
        if (finish_s[k] && !fin_prev[k]) begin
          check($sformatf("finish_delay_inst%0d", k), cyc - last_valid[k], 1);
          check($sformatf("encode_at_finish_inst%0d", k), int'(encode_s[k]), 0);
        end
        fin_prev[k] = finish_s[k];
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    char_valid[0] = 1'b0;
    char_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic check_zero(input int inst, input string name);
    check({name, "_valid"}, int'(valid_s[inst]), 0);
    check({name, "_finish"}, int'(finish_s[inst]), 0);
    check({name, "_encode"}, int'(encode_s[inst]), 0);
    check({name, "_offset"}, int'(offset_s[inst]), 0);
    check({name, "_match_len"}, int'(len_s[inst]), 0);
    check({name, "_char_nxt"}, int'(char_s[inst]), 0);
  endtask

  // Feed stim_q (plus optional '$'), then measure latency to the first codeword.
  task automatic send(input int inst, input bit term);
    int k;
    foreach (stim_q[i]) begin
      @(negedge clk);
      char_valid[inst] = 1'b1;
      chardata[inst] = stim_q[i];
    end
    if (term) begin
      @(negedge clk);
      char_valid[inst] = 1'b1;
      chardata[inst] = END_CHAR;
    end
    check($sformatf("encode_active_inst%0d", inst), int'(encode_s[inst]), 1);
    @(negedge clk);
    char_valid[inst] = 1'b0;
    chardata[inst] = 8'h00;
    k = 0;
    while (k < 40 && !valid_s[inst]) begin
      @(posedge clk);
      #1;
      k++;
    end
    check($sformatf("first_latency_inst%0d", inst), k, LAT);
  endtask

  task automatic wait_finish(input int inst, input string name);
    int k;
    k = 0;
    while (k < 300 && !finish_s[inst]) begin
      @(negedge clk);
      k++;
    end
    check({name, "_finished"}, int'(finish_s[inst]), 1);
    @(negedge clk);
    check({name, "_queue_drained"}, (inst == 0) ? exp_q0.size() : exp_q1.size(), 0);
  endtask

  initial begin
    char_valid[0] = 1'b0;
    char_valid[1] = 1'b0;
    chardata[0] = 8'h00;
    chardata[1] = 8'h00;
    last_valid[0] = 0;
    last_valid[1] = 0;
    fin_prev[0] = 1'b0;
    fin_prev[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero(0, "reset_a");
    check_zero(1, "reset_b");
    @(negedge clk);
    reset = 1'b0;

    // Four zeros: literal then an overlapping run of 3 to the end.
    stim_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    expect_cw(0, 4'd0, 3'd0, 8'h00);
    expect_cw(0, 4'd0, 3'd3, 8'h24);
    send(0, 1'b1);
    wait_finish(0, "zeros");

    // Repeating pair followed by a new symbol.
    do_reset();
    stim_q = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02, 8'h03};
    expect_cw(0, 4'd0, 3'd0, 8'h01);
    expect_cw(0, 4'd0, 3'd0, 8'h02);
    expect_cw(0, 4'd1, 3'd4, 8'h03);
    expect_cw(0, 4'd0, 3'd0, 8'h24);
    send(0, 1'b1);
    wait_finish(0, "pairs");

    // Empty string.
    do_reset();
    stim_q.delete();
    expect_cw(0, 4'd0, 3'd0, 8'h24);
    send(0, 1'b1);
    wait_finish(0, "empty");

    // Twenty 5s: max-length matches and tie-break to offset 0.
    do_reset();
    stim_q.delete();
    repeat (20) stim_q.push_back(8'h05);
    expect_cw(0, 4'd0, 3'd0, 8'h05);
    expect_cw(0, 4'd0, 3'd7, 8'h05);
    expect_cw(0, 4'd0, 3'd7, 8'h05);
    expect_cw(0, 4'd0, 3'd3, 8'h24);
    send(0, 1'b1);
    wait_finish(0, "fives");

    // MAX_LEN=16 instance: sixteen 7s, implicit terminator.
    do_reset();
    stim_q.delete();
    repeat (16) stim_q.push_back(8'h07);
    expect_cw(1, 4'd0, 3'd0, 8'h07);
    expect_cw(1, 4'd0, 3'd7, 8'h07);
    expect_cw(1, 4'd0, 3'd7, 8'h24);
    send(1, 1'b0);
    wait_finish(1, "implicit_end");

    // Reset during the 4th cycle of the second search pass.
    do_reset();
    stim_q = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02, 8'h03};
    expect_cw(0, 4'd0, 3'd0, 8'h01);
    send(0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero(0, "midsearch_reset");
    check("midsearch_queue_drained", exp_q0.size(), 0);
    @(negedge clk);
    reset = 1'b0;

    // Fresh string after the interrupted one; upper nibble of 8'h33 is ignored.
    stim_q = '{8'h33, 8'h03, 8'h04, 8'h03, 8'h03, 8'h04};
    expect_cw(0, 4'd0, 3'd0, 8'h03);
    expect_cw(0, 4'd0, 3'd1, 8'h04);
    expect_cw(0, 4'd2, 3'd3, 8'h24);
    send(0, 1'b1);
    wait_finish(0, "fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
